// File: rtl/soc_io_matrix.sv
// Memory-mapped LED-matrix scanner and debounced key block on the core's mem_* bus.
// Optional key interrupt with mask register: define SOC_IO_KEY_IRQ_EN.
module soc_io_matrix #(
  parameter logic [31:0] BASE_ADDR       = 32'hF000_0000,
  parameter int          N_COLS          = 4,
  parameter int          N_ROWS          = 8,
  parameter int          N_KEYS          = 4,
  parameter int          SCAN_DIV        = 12000,
  parameter int          DEBOUNCE_CYCLES = 1024,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_wstrobe,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_ROWS-1:0] led_row,
  output logic [N_COLS-1:0] led_col,
  output logic              irq
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(N_COLS - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  // Word index (mem_addr[7:2]) of the control registers above the framebuffer.
  typedef enum logic [5:0] {
    W_KEY_STATE = 6'h10,
    W_KEY_EVENT = 6'h11,
    W_SCAN_CTRL = 6'h12,
    W_IRQ_MASK  = 6'h13
  } reg_word_e;

  logic        hit, wr;
  logic [5:0]  widx;
  logic        unused_ok;

  assign hit       = mem_req && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr        = hit && mem_wstrobe;
  assign widx      = mem_addr[7:2];
  assign unused_ok = ^{mem_addr[1:0], mem_wdata};

  logic [N_ROWS-1:0] fb_q [N_COLS];
  logic [N_ROWS-1:0] fb_d [N_COLS];
  logic              scan_en_q, scan_en_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [N_ROWS-1:0] led_row_q, led_row_d;
  logic [N_COLS-1:0] led_col_q, led_col_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q;

  logic [N_KEYS-1:0] key_norm, sync1_q, sync2_q;
  logic [N_KEYS-1:0] key_state_q, key_state_d;
  logic [N_KEYS-1:0] key_event_q, key_event_d;
  logic [N_KEYS-1:0] ev_clr;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];
  logic [DB_W-1:0]   db_cnt_d [N_KEYS];

  assign key_norm = KEY_ACTIVE_LOW ? ~keys : keys;

`ifdef SOC_IO_KEY_IRQ_EN
  logic [N_KEYS-1:0] irq_mask_q, irq_mask_d;
  logic              irq_q;
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    scan_en_d = scan_en_q;
    for (int c = 0; c < N_COLS; c++) begin
      fb_d[c] = fb_q[c];
      if (wr && widx == 6'(c)) fb_d[c] = mem_wdata[N_ROWS-1:0];
    end
    if (wr && widx == W_SCAN_CTRL) scan_en_d = mem_wdata[0];
    ev_clr = (wr && widx == W_KEY_EVENT) ? mem_wdata[N_KEYS-1:0] : '0;
`ifdef SOC_IO_KEY_IRQ_EN
    irq_mask_d = irq_mask_q;
    if (wr && widx == W_IRQ_MASK) irq_mask_d = mem_wdata[N_KEYS-1:0];
`endif
  end

  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (widx == 6'(c)) rdata_d = 32'(fb_q[c]);
    end
    case (widx)
      W_KEY_STATE: rdata_d = 32'(key_state_q);
      W_KEY_EVENT: rdata_d = 32'(key_event_q);
      W_SCAN_CTRL: rdata_d = 32'(scan_en_q);
`ifdef SOC_IO_KEY_IRQ_EN
      W_IRQ_MASK:  rdata_d = 32'(irq_mask_q);
`endif
      default: ;
    endcase
  end

  // Outputs are registered from the next counter state so they line up with the counter.
  always_comb begin
    scan_cnt_d = '0;
    col_d      = '0;
    if (scan_en_q) begin
      if (scan_cnt_q == SCAN_LAST) begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
      end else begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        col_d      = col_q;
      end
    end
    led_col_d = '1;
    led_row_d = '1;
    if (scan_cnt_d != '0) begin
      led_col_d[col_d] = 1'b0;
      led_row_d        = ~fb_q[col_d];
    end
  end

  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      key_state_d[k] = key_state_q[k];
      db_cnt_d[k]    = '0;
      if (sync2_q[k] != key_state_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) key_state_d[k] = sync2_q[k];
        else                        db_cnt_d[k]    = db_cnt_q[k] + DB_W'(1);
      end
    end
    // A press edge landing with a W1C of the same bit keeps the bit set.
    key_event_d = (key_event_q & ~ev_clr) | (key_state_d & ~key_state_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the framebuffer is a small flop array, so it is reset like any other register.
      for (int c = 0; c < N_COLS; c++) fb_q[c] <= '0;
      for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= '0;
      scan_en_q   <= 1'b1;
      scan_cnt_q  <= '0;
      col_q       <= '0;
      led_row_q   <= '1;
      led_col_q   <= '1;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_state_q <= '0;
      key_event_q <= '0;
`ifdef SOC_IO_KEY_IRQ_EN
      irq_mask_q  <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < N_COLS; c++) fb_q[c] <= fb_d[c];
      for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
      scan_en_q   <= scan_en_d;
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      led_row_q   <= led_row_d;
      led_col_q   <= led_col_d;
      done_q      <= hit;
      if (hit) rdata_q <= rdata_d;
      sync1_q     <= key_norm;
      sync2_q     <= sync1_q;
      key_state_q <= key_state_d;
      key_event_q <= key_event_d;
`ifdef SOC_IO_KEY_IRQ_EN
      irq_mask_q  <= irq_mask_d;
      irq_q       <= |(key_event_q & irq_mask_q);
`endif
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_done  = done_q;
  assign led_row   = led_row_q;
  assign led_col   = led_col_q;

endmodule
